// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter family.
// Holds the FSM state encoding, the default timeout read data and the watchdog width.
// Later N-master arbiters reuse the same encodings.
package wb_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA_DFLT = 32'hDEAD_BEEF;

  // Watchdog counter width: covers the full legal TIMEOUT_CYC range.
  localparam int WD_CNT_W = 16;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Purpose: 2-way round-robin chooser. The winner is the requester that was not served last.
// Latency: purely combinational, with no state.
// Backpressure: none. The caller decides when to act on pick and valid.
module wb_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       valid
);

  // A single requester always wins. A tie goes to the master that was not last.
  always_comb begin
    valid = |req;
    pick  = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Purpose: shares one Wishbone slave between the mgmt core (wbs_*) and a user master (m1_*).
//          Round-robin grant; the grant stays locked while the owner holds cyc.
// Latency: a request sampled in IDLE is forwarded to the slave from the next cycle.
//          The bus returns to IDLE for one cycle between owners.
// Backpressure: the slave stalls by withholding s_ack_i. The non-owner waits with no ack.
//          WB_ARB_TIMEOUT_EN adds a watchdog that terminates stalled accesses.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          TIMEOUT_CYC  = 255,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DFLT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // master 0: management core
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  // master 1: internal user master
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic              m1_ack_o,
  output logic [31:0]       m1_dat_o,
  // shared slave
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [31:0]       s_dat_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  // status
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYC must be in 2..65535");
  end

  arb_state_t state;
  logic       last;
  logic [1:0] req;
  logic       pick;
  logic       pick_vld;
  logic       own0;
  logic       own1;
  logic       stb_raw;
  logic       slv_ack;
  logic       wd_fire;

  assign req = {m1_cyc_i & m1_stb_i, wbs_cyc_i & wbs_stb_i};

  wb_arb_rr_pick u_pick (
    .req   (req),
    .last  (last),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Ownership is masked during reset so that a reset mid-transfer never leaks an ack or a strobe.
  assign own0 = (state == ST_OWN0) & ~wb_rst_i;
  assign own1 = (state == ST_OWN1) & ~wb_rst_i;

  // Grant FSM: IDLE picks round-robin, and OWNx holds until that master drops cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) state <= pick ? ST_OWN1 : ST_OWN0;
        end
        ST_OWN0: begin
          if (!wbs_cyc_i) begin
            state <= ST_IDLE;
            last  <= 1'b0;
          end
        end
        ST_OWN1: begin
          if (!m1_cyc_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o = {state == ST_OWN1, state == ST_OWN0};

  // Forward the owner's request to the slave. The strobe is qualified by cyc so that a dropped
  // cycle kills the strobe in the same cycle.
  always_comb begin
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own0) begin
      s_cyc_o = wbs_cyc_i;
      stb_raw = wbs_cyc_i & wbs_stb_i;
      s_we_o  = wbs_we_i;
      s_sel_o = wbs_sel_i;
      s_adr_o = wbs_adr_i;
      s_dat_o = wbs_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      stb_raw = m1_cyc_i & m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // A watchdog termination withdraws the strobe, so any slave ack in that cycle is ignored.
  assign s_stb_o = stb_raw & ~wd_fire;
  assign slv_ack = s_ack_i & s_stb_o;

  assign wbs_ack_o = own0 & (slv_ack | wd_fire);
  assign m1_ack_o  = own1 & (slv_ack | wd_fire);
  assign wbs_dat_o = own0 ? (wd_fire ? TIMEOUT_DATA : s_dat_i) : 32'h0;
  assign m1_dat_o  = own1 ? (wd_fire ? TIMEOUT_DATA : s_dat_i) : 32'h0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [WD_CNT_W-1:0] WD_LIMIT = WD_CNT_W'(TIMEOUT_CYC);

  logic [WD_CNT_W-1:0] wd_cnt;
  logic                wd_flag;

  // The watchdog fires on the cycle after TIMEOUT_CYC consecutive stalled strobe cycles.
  assign wd_fire = stb_raw & (wd_cnt == WD_LIMIT);

  // Count stalled strobe cycles. Clear the count on ack, on an idle strobe and on termination.
  // The flag is sticky until reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (wd_fire) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b1;
    end else if (!s_stb_o || s_ack_i) begin
      wd_cnt  <= '0;
    end else begin
      wd_cnt  <= wd_cnt + WD_CNT_W'(1);
    end
  end

  assign timeout_o = wd_flag;
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m. It covers reset/idle, single write, tie-break,
// burst lock, reset and drop mid-transfer, and the watchdog (behaviour follows WB_ARB_TIMEOUT_EN).
// Expected acks are queued when the slave response is driven, then matched at the master side.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  typedef struct packed {
    logic [1:0]  who;   // {m1, m0} ack expected
    logic [31:0] dat;
  } sb_t;

  sb_t sb_q[$];
  sb_t e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  found;
  int  ack_cyc;

  always #5 clk = ~clk;

  wb_arbiter_2m #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (8),
    .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_sel_i (m1_sel_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_ack_o (m1_ack_o),
    .m1_dat_o (m1_dat_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .gnt_o    (gnt_o),
    .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic m0_set(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    wbs_cyc_i = c; wbs_stb_i = s; wbs_we_i = w;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = 4'hF;
  endtask

  task automatic m1_set(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    m1_cyc_i = c; m1_stb_i = s; m1_we_i = w;
    m1_adr_i = a; m1_dat_i = d; m1_sel_i = 4'h3;
  endtask

  // Scoreboard side: every master-side ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wbs_ack_o || m1_ack_o) begin
      if (sb_q.size() == 0) begin
        chk("unexp_ack", {m1_ack_o, wbs_ack_o}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        chk("ack_who", {m1_ack_o, wbs_ack_o}, e.who);
        chk("ack_dat", e.who[1] ? m1_dat_o : wbs_dat_o, e.dat);
        chk("ack_other_dat", e.who[1] ? wbs_dat_o : m1_dat_o, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench stuck");
  end

  initial begin
    rst = 1'b1; s_ack_i = 1'b0; s_dat_i = 32'h0;
    m0_set(0, 0, 0, 32'h0, 32'h0);
    m1_set(0, 0, 0, 32'h0, 32'h0);
    wbs_sel_i = 4'h0; m1_sel_i = 4'h0;
    step(); step();
    at_neg();
    chk("rst_ctl", {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, wbs_ack_o, m1_ack_o, timeout_o}, 12'h0);
    step(); rst = 1'b0;

    // Idle with random slave data on the bus: nothing may leak through.
    for (int i = 0; i < 10; i++) begin
      s_dat_i = $urandom;
      at_neg();
      chk("idle_ctl", {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, wbs_ack_o, m1_ack_o, timeout_o}, 12'h0);
      chk("idle_bus", {s_adr_o, s_dat_o}, 64'h0);
      chk("idle_mdat", {wbs_dat_o, m1_dat_o}, 64'h0);
      step();
    end
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("spur_ack", {wbs_ack_o, m1_ack_o}, 2'b00);
      step();
    end
    s_ack_i = 1'b0;

    // Single master 0 write.
    m0_set(1, 1, 1, 32'h3000_0004, 32'h0000_AB60);
    at_neg(); chk("m0_pre_cyc", s_cyc_o, 1'b0);
    step(); at_neg();
    chk("m0_gnt", gnt_o, 2'b01);
    chk("m0_adr", s_adr_o, 32'h3000_0004);
    chk("m0_dat", s_dat_o, 32'h0000_AB60);
    chk("m0_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, 7'b111_1111);
    step(); s_ack_i = 1'b1; s_dat_i = 32'h0; sb_q.push_back('{2'b01, 32'h0});
    at_neg();
    step(); s_ack_i = 1'b0; m0_set(0, 0, 0, 32'h0, 32'h0);
    at_neg(); chk("m0_ack_once", wbs_ack_o, 1'b0);
    step();

    // Tie-break after reset: master 0 wins first, then master 1.
    rst = 1'b1; step(); rst = 1'b0;
    m0_set(1, 1, 0, 32'h0000_0100, 32'h0);
    m1_set(1, 1, 0, 32'h0000_0200, 32'h0);
    at_neg(); chk("tie_pre_gnt", gnt_o, 2'b00);
    step(); at_neg();
    chk("tie_gnt", gnt_o, 2'b01);
    chk("tie_adr", s_adr_o, 32'h0000_0100);
    step(); s_ack_i = 1'b1; s_dat_i = 32'hC0DE_0001; sb_q.push_back('{2'b01, 32'hC0DE_0001});
    at_neg();
    step(); s_ack_i = 1'b0; m0_set(0, 0, 0, 32'h0, 32'h0);
    at_neg(); chk("rel_cyc", s_cyc_o, 1'b0);
    step(); m0_set(1, 1, 0, 32'h0000_0104, 32'h0);
    at_neg();
    chk("gap_cyc", s_cyc_o, 1'b0);
    chk("gap_gnt", gnt_o, 2'b00);
    step(); at_neg();
    chk("rr_gnt", gnt_o, 2'b10);
    chk("rr_adr", s_adr_o, 32'h0000_0200);

    // Master 1 holds a 4-beat read burst with an stb gap; master 0 keeps requesting.
    for (int i = 0; i < 4; i++) begin
      step(); s_ack_i = 1'b1; s_dat_i = 32'hB000_0000 + i;
      sb_q.push_back('{2'b10, 32'hB000_0000 + i});
      at_neg(); chk("lock_gnt", gnt_o, 2'b10);
      step(); s_ack_i = 1'b0;
      if (i == 1) begin
        m1_stb_i = 1'b0;
        at_neg();
        chk("lock_gap_gnt", gnt_o, 2'b10);
        chk("lock_gap_stb", s_stb_o, 1'b0);
        step(); m1_stb_i = 1'b1;
      end
    end
    m1_set(0, 0, 0, 32'h0, 32'h0);
    at_neg(); chk("m1_rel_cyc", s_cyc_o, 1'b0);
    step(); at_neg(); chk("m1_rel_idle", gnt_o, 2'b00);
    step(); at_neg();
    chk("m0_after_lock", gnt_o, 2'b01);
    chk("m0_after_adr", s_adr_o, 32'h0000_0104);
    step(); s_ack_i = 1'b1; s_dat_i = 32'h5A5A_0104; sb_q.push_back('{2'b01, 32'h5A5A_0104});
    at_neg();
    step(); s_ack_i = 1'b0; m0_set(0, 0, 0, 32'h0, 32'h0);
    step();

    // Reset while master 0 owns a stalled access.
    m0_set(1, 1, 0, 32'h0000_0200, 32'h0);
    step(); at_neg(); chk("rst_own0", gnt_o, 2'b01);
    step(); rst = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'h1111_1111;
    at_neg();
    chk("rst_mid_ack", {wbs_ack_o, m1_ack_o}, 2'b00);
    chk("rst_mid_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    step(); rst = 1'b0; s_ack_i = 1'b0; m0_set(0, 0, 0, 32'h0, 32'h0);
    at_neg();
    chk("rst_mid_gnt", gnt_o, 2'b00);
    chk("rst_mid_ack2", wbs_ack_o, 1'b0);
    step();

    // Master 1 drops cyc before the slave answers; the late ack must vanish.
    m1_set(1, 1, 0, 32'h0000_0300, 32'h0);
    step(); at_neg();
    chk("drop_gnt", gnt_o, 2'b10);
    chk("drop_stb_pre", s_stb_o, 1'b1);
    step(); m1_set(0, 0, 0, 32'h0, 32'h0); s_ack_i = 1'b1; s_dat_i = 32'h2222_2222;
    at_neg();
    chk("drop_stb", {s_cyc_o, s_stb_o}, 2'b00);
    chk("late_ack", m1_ack_o, 1'b0);
    step(); s_ack_i = 1'b0;
    at_neg(); chk("drop_idle", gnt_o, 2'b00);
    step();

    // Slave never answers a master 0 read.
    s_dat_i = 32'h0BAD_0000;
`ifdef WB_ARB_TIMEOUT_EN
    sb_q.push_back('{2'b01, 32'hDEAD_BEEF});
`endif
    m0_set(1, 1, 0, 32'h0000_0400, 32'h0);
    found = 0; ack_cyc = 0;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step(); at_neg();
      if (wbs_ack_o) begin
        found = 1; ack_cyc = c;
      end
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("wd_seen", found, 1);
    chk("wd_cyc", ack_cyc, 9);
    chk("wd_stb", s_stb_o, 1'b0);
    step(); m0_set(0, 0, 0, 32'h0, 32'h0);
    at_neg(); chk("wd_flag", timeout_o, 1'b1);
    step(); step(); step();
    at_neg(); chk("wd_sticky", timeout_o, 1'b1);
    step(); rst = 1'b1; step(); rst = 1'b0;
    at_neg(); chk("wd_clr", timeout_o, 1'b0);
`else
    chk("wd_none", found, 0);
    chk("wd_flag_off", timeout_o, 1'b0);
    step(); m0_set(0, 0, 0, 32'h0, 32'h0);
`endif
    step(); step();
    at_neg();
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
